// File: rtl/alsu_pkg.sv
// Shared ALSU definitions: operand width, result-FIFO occupancy states and
// the sign-magnitude result type.
package alsu_pkg;

   localparam int ALSU_DATA_W = 4;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   typedef struct packed {
      logic                   sign;
      logic [ALSU_DATA_W-1:0] mag;
   } sm_t;

endpackage

// File: rtl/dec_result_fifo2.sv
// Generic two-entry register FIFO; status flags come only from registered
// occupancy, so the consumer's ready never reaches the producer combinationally.
module dec_result_fifo2
   import alsu_pkg::*;
#(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   occ_e         state_q;
   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic         push_ok;
   logic         pop_ok;

   assign full_o  = (state_q == TWO);
   assign empty_o = (state_q == EMPTY);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         // Push+pop in ONE leaves occupancy unchanged; the tail slot becomes head.
         unique case (state_q)
            EMPTY:   if (push_ok) state_q <= ONE;
            ONE: begin
               if (push_ok && !pop_ok)      state_q <= TWO;
               else if (pop_ok && !push_ok) state_q <= EMPTY;
            end
            TWO:     if (pop_ok) state_q <= ONE;
            default: state_q <= EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/dec_result_stage.sv
// Output stage after the ALSU decrementer: packs A/B into sign-magnitude,
// buffers them in a 2-deep FIFO and keeps a saturating negative-result count.
module dec_result_stage
   import alsu_pkg::*;
#(
   parameter int DATA_W = ALSU_DATA_W,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] A_Dec,
   input  logic [DATA_W-1:0] B_Dec,
   input  logic              Negative_Sign_Flag_A,
   input  logic              Negative_Sign_Flag_B,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W:0]   out_A,
   output logic [DATA_W:0]   out_B,
   output logic [CNT_W-1:0]  neg_count,
   input  logic              neg_count_clr
);

   // A zero magnitude is always reported as positive.
   function automatic logic [DATA_W:0] pack_sm(input logic [DATA_W-1:0] mag,
                                               input logic              neg);
      return {neg && (mag != '0), mag};
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic [1:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, cnt} + (CNT_W+1)'(inc);
      return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   endfunction

   logic [DATA_W:0]     pack_a;
   logic [DATA_W:0]     pack_b;
   logic [2*DATA_W+1:0] head;
   logic                push;
   logic                pop;
   logic                full;
   logic                empty;
   logic [1:0]          neg_inc;
   logic [CNT_W-1:0]    neg_count_q;
   logic [CNT_W-1:0]    neg_count_d;

   assign pack_a    = pack_sm(A_Dec, Negative_Sign_Flag_A);
   assign pack_b    = pack_sm(B_Dec, Negative_Sign_Flag_B);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_A     = head[2*DATA_W+1:DATA_W+1];
   assign out_B     = head[DATA_W:0];
   assign neg_count = neg_count_q;

   dec_result_fifo2 #(
      .W(2*DATA_W+2)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (push),
      .wdata_i({pack_a, pack_b}),
      .pop_i  (pop),
      .rdata_o(head),
      .full_o (full),
      .empty_o(empty)
   );

   assign neg_inc = {1'b0, pack_a[DATA_W]} + {1'b0, pack_b[DATA_W]};

   always_comb begin
      neg_count_d = neg_count_q;
      if (neg_count_clr)  neg_count_d = '0;
      else if (push)      neg_count_d = sat_add(neg_count_q, neg_inc);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) neg_count_q <= '0;
      else        neg_count_q <= neg_count_d;
   end

endmodule

// File: tb/tb_dec_result_stage.sv
// Randomised and directed bench for dec_result_stage against a queue-based
// reference model of the sign-magnitude result buffer.
module tb_dec_result_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] A_Dec;
   logic [3:0] B_Dec;
   logic       Negative_Sign_Flag_A;
   logic       Negative_Sign_Flag_B;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_A;
   logic [4:0] out_B;
   logic [3:0] neg_count;
   logic       neg_count_clr;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: queue of packed results plus the counter value.
   int q_a[$];
   int q_b[$];
   int m_cnt = 0;

   always #5 clk = ~clk;

   dec_result_stage #(.DATA_W(4), .CNT_W(4)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .A_Dec               (A_Dec),
      .B_Dec               (B_Dec),
      .Negative_Sign_Flag_A(Negative_Sign_Flag_A),
      .Negative_Sign_Flag_B(Negative_Sign_Flag_B),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_A               (out_A),
      .out_B               (out_B),
      .neg_count           (neg_count),
      .neg_count_clr       (neg_count_clr)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      tests_run++;
      if (obs != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_pack(input int mag, input bit neg);
      return (neg && mag != 0) ? 16 + mag : mag;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".out_valid"}, int'(out_valid), int'(q_a.size() > 0));
      chk({tag, ".in_ready"},  int'(in_ready),  int'(q_a.size() < 2));
      chk({tag, ".neg_count"}, int'(neg_count), m_cnt);
      if (q_a.size() > 0) begin
         chk({tag, ".out_A"}, int'(out_A), q_a[0]);
         chk({tag, ".out_B"}, int'(out_B), q_b[0]);
      end
   endtask

   // Drive one cycle (inputs applied at the falling edge), advance the model
   // at the rising edge, then compare on the next falling edge.
   task automatic step(input string tag, input bit r, input bit iv,
                       input int a, input bit fa, input int b, input bit fb,
                       input bit ordy, input bit clr);
      bit push, pop;
      int pa, pb, inc;
      rst_n = r; in_valid = iv; A_Dec = 4'(a); B_Dec = 4'(b);
      Negative_Sign_Flag_A = fa; Negative_Sign_Flag_B = fb;
      out_ready = ordy; neg_count_clr = clr;
      @(posedge clk);
      if (!r) begin
         q_a.delete(); q_b.delete(); m_cnt = 0;
      end else begin
         push = iv && (q_a.size() < 2);
         pop  = ordy && (q_a.size() > 0);
         pa = ref_pack(a, fa);
         pb = ref_pack(b, fb);
         inc = (pa >= 16 ? 1 : 0) + (pb >= 16 ? 1 : 0);
         if (pop) begin
            void'(q_a.pop_front());
            void'(q_b.pop_front());
         end
         if (push) begin
            q_a.push_back(pa);
            q_b.push_back(pb);
         end
         if (clr)       m_cnt = 0;
         else if (push) m_cnt = (m_cnt + inc > 15) ? 15 : m_cnt + inc;
      end
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; A_Dec = '0; B_Dec = '0;
      Negative_Sign_Flag_A = 1'b0; Negative_Sign_Flag_B = 1'b0;
      out_ready = 1'b0; neg_count_clr = 1'b0;
      @(negedge clk);

      step("rst", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst.out_A", int'(out_A), 0);
      chk("rst.out_B", int'(out_B), 0);

      // First result: A=+5, B=-1.
      step("tp1", 1, 1, 5, 0, 1, 1, 1, 0);
      chk("tp1.out_A", int'(out_A), 5'b0_0101);
      chk("tp1.out_B", int'(out_B), 5'b1_0001);
      chk("tp1.cnt", int'(neg_count), 1);

      // Negative zero normalised, also a push+pop in ONE.
      step("zero", 1, 1, 0, 1, 2, 0, 1, 0);
      chk("zero.out_A", int'(out_A), 0);
      chk("zero.cnt", int'(neg_count), 1);
      step("drain", 1, 0, 0, 0, 0, 0, 1, 0);

      // Backpressure: three pushes with consumer stalled.
      step("bp1", 1, 1, 3, 0, 4, 1, 0, 0);
      step("bp2", 1, 1, 6, 1, 7, 0, 0, 0);
      chk("bp2.in_ready", int'(in_ready), 0);
      step("bp3", 1, 1, 8, 1, 9, 1, 0, 0);
      chk("bp3.hold_A", int'(out_A), 5'b0_0011);
      step("bp4", 1, 1, 8, 1, 9, 1, 1, 0);
      chk("bp4.in_ready", int'(in_ready), 1);
      step("bp5", 1, 1, 8, 1, 9, 1, 1, 0);
      step("bp6", 1, 0, 0, 0, 0, 0, 1, 0);
      step("bp7", 1, 0, 0, 0, 0, 0, 1, 0);

      // Saturation then clear with priority over a negative push.
      for (int i = 0; i < 10; i++) step("sat", 1, 1, 1, 1, 1, 1, 1, 0);
      chk("sat.cnt", int'(neg_count), 15);
      step("clr", 1, 1, 2, 1, 3, 1, 1, 1);
      chk("clr.cnt", int'(neg_count), 0);

      // Reset while full.
      step("full1", 1, 1, 4, 1, 5, 0, 0, 0);
      step("full2", 1, 1, 6, 0, 7, 1, 0, 0);
      step("rstfull", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rstfull.out_valid", int'(out_valid), 0);
      chk("rstfull.in_ready", int'(in_ready), 1);
      step("post", 1, 1, 9, 0, 10, 1, 0, 0);
      chk("post.out_B", int'(out_B), 5'b1_1010);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step("rnd", ($urandom_range(0, 63) != 0), $urandom_range(0, 1),
              $urandom_range(0, 15), $urandom_range(0, 1),
              $urandom_range(0, 15), $urandom_range(0, 1),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
